// File: rtl/product_price_table.sv
// product_price_table: registered one-hot product lookup with programmable prices,
// per-slot stock counters and vend accept/reject handling.
module product_price_table #(
   parameter int NUM_PRODUCTS = 4,
   parameter int PRICE_W      = 8,
   parameter int STOCK_W      = 4,
   parameter int INIT_STOCK   = 5,
   parameter int SEL_W        = $clog2(NUM_PRODUCTS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_PRODUCTS-1:0] product_code,
   input  logic                    lookup_req,
   input  logic                    vend_req,
   input  logic                    cfg_price_we,
   input  logic                    cfg_stock_we,
   input  logic [SEL_W-1:0]        cfg_sel,
   input  logic [PRICE_W-1:0]      cfg_price,
   input  logic [STOCK_W-1:0]      cfg_stock,
   output logic [PRICE_W-1:0]      product_price,
   output logic [STOCK_W-1:0]      stock_count,
   output logic                    price_valid,
   output logic                    code_error,
   output logic                    vend_ack,
   output logic                    vend_fail
);
   logic [PRICE_W-1:0]      price [NUM_PRODUCTS];
   logic [STOCK_W-1:0]      stock [NUM_PRODUCTS];
   logic [PRICE_W-1:0]      sel_price;
   logic [STOCK_W-1:0]      sel_stock;
   logic [NUM_PRODUCTS-1:0] restock_hit;
   logic                    onehot;
   logic                    vend_ok;

   // Legacy fixed price map, extended with zero-priced slots
   function automatic logic [PRICE_W-1:0] reset_price(input int i);
      return i == 0 ? PRICE_W'(1) : i == 1 ? PRICE_W'(2) : i == 2 ? PRICE_W'(5) :
             i == 3 ? PRICE_W'(10) : '0;
   endfunction

   assign onehot = $onehot(product_code);

   // An invalid code selects no slot, so price/stock read back as zero
   always_comb begin
      sel_price   = '0;
      sel_stock   = '0;
      restock_hit = '0;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         if (product_code == NUM_PRODUCTS'(1) << i) begin
            sel_price = price[i];
            sel_stock = stock[i];
         end
         restock_hit[i] = cfg_stock_we && cfg_sel == SEL_W'(i);
      end
   end

   // A restock of the vended slot in the same cycle takes priority and rejects the vend
   assign vend_ok = onehot && sel_stock != '0 && (restock_hit & product_code) == '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PRODUCTS; i++) begin
            price[i] <= reset_price(i);
            stock[i] <= STOCK_W'(INIT_STOCK);
         end
         product_price <= '0;
         stock_count   <= '0;
         price_valid   <= 1'b0;
         code_error    <= 1'b0;
         vend_ack      <= 1'b0;
         vend_fail     <= 1'b0;
      end else begin
         price_valid <= lookup_req;
         code_error  <= lookup_req && !onehot;
         vend_ack    <= vend_req && vend_ok;
         vend_fail   <= vend_req && !vend_ok;
         if (lookup_req) begin
            product_price <= sel_price;
            stock_count   <= sel_stock;
         end
         for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (cfg_price_we && cfg_sel == SEL_W'(i)) price[i] <= cfg_price;
            if (restock_hit[i]) stock[i] <= cfg_stock;
            else if (vend_req && vend_ok && product_code[i]) stock[i] <= stock[i] - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_product_price_table.sv
// tb_product_price_table: directed stimulus with a queue scoreboard checked by a monitor.
module tb_product_price_table;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] product_code;
   logic       lookup_req, vend_req, cfg_price_we, cfg_stock_we;
   logic [1:0] cfg_sel;
   logic [7:0] cfg_price;
   logic [3:0] cfg_stock;
   logic [7:0] product_price;
   logic [3:0] stock_count;
   logic       price_valid, code_error, vend_ack, vend_fail;

   typedef struct {int cyc; logic [7:0] p; logic [3:0] s; logic e;} lk_t;
   typedef struct {int cyc; logic ack;} vd_t;
   lk_t lq[$];
   vd_t vq[$];
   int  cyc = 0;
   int  compared = 0;
   int  mismatched = 0;

   product_price_table dut (
      .clk(clk), .rst_n(rst_n), .product_code(product_code), .lookup_req(lookup_req),
      .vend_req(vend_req), .cfg_price_we(cfg_price_we), .cfg_stock_we(cfg_stock_we),
      .cfg_sel(cfg_sel), .cfg_price(cfg_price), .cfg_stock(cfg_stock),
      .product_price(product_price), .stock_count(stock_count), .price_valid(price_valid),
      .code_error(code_error), .vend_ack(vend_ack), .vend_fail(vend_fail)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every pulse must match the oldest expectation, in the right cycle
   always @(negedge clk) begin
      lk_t le;
      vd_t ve;
      if (code_error && !price_valid) begin
         compared++;
         mismatched++;
         $display("FAIL code_error_alone cycle %0d: code_error=1 without price_valid", cyc);
      end
      if (price_valid) begin
         compared++;
         if (lq.size() == 0) begin
            mismatched++;
            $display("FAIL lookup_unexpected cycle %0d: price_valid=1 with nothing expected", cyc);
         end else begin
            le = lq.pop_front();
            if (le.cyc != cyc || product_price != le.p || stock_count != le.s || code_error != le.e) begin
               mismatched++;
               $display("FAIL lookup cycle/price/stock/err got %0d/%0d/%0d/%0b need %0d/%0d/%0d/%0b",
                        cyc, product_price, stock_count, code_error, le.cyc, le.p, le.s, le.e);
            end
         end
      end
      if (vend_ack || vend_fail) begin
         compared++;
         if (vq.size() == 0) begin
            mismatched++;
            $display("FAIL vend_unexpected cycle %0d: ack=%0b fail=%0b", cyc, vend_ack, vend_fail);
         end else begin
            ve = vq.pop_front();
            if (ve.cyc != cyc || vend_ack != ve.ack || vend_fail != !ve.ack) begin
               mismatched++;
               $display("FAIL vend cycle/ack/fail got %0d/%0b/%0b need %0d/%0b/%0b",
                        cyc, vend_ack, vend_fail, ve.cyc, ve.ack, !ve.ack);
            end
         end
      end
   end

   // One clock of stimulus; expectations are pushed for the answer one cycle later
   task automatic drive(input logic lk, input logic vd, input logic [3:0] code,
                        input logic pwe, input logic swe, input logic [1:0] sel,
                        input logic [7:0] cp, input logic [3:0] cs,
                        input logic [7:0] ep, input logic [3:0] es, input logic ee,
                        input logic eack);
      lookup_req = lk; vend_req = vd; product_code = code;
      cfg_price_we = pwe; cfg_stock_we = swe; cfg_sel = sel; cfg_price = cp; cfg_stock = cs;
      if (lk && rst_n) lq.push_back('{cyc + 1, ep, es, ee});
      if (vd && rst_n) vq.push_back('{cyc + 1, eack});
      @(negedge clk);
   endtask

   task automatic look(input logic [3:0] code, input logic [7:0] ep, input logic [3:0] es, input logic ee);
      drive(1, 0, code, 0, 0, 0, 0, 0, ep, es, ee, 0);
   endtask

   task automatic vend(input logic [3:0] code, input logic eack);
      drive(0, 1, code, 0, 0, 0, 0, 0, 0, 0, 0, eack);
   endtask

   task automatic idle();
      drive(0, 0, 4'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      lookup_req = 0; vend_req = 0; product_code = 0;
      cfg_price_we = 0; cfg_stock_we = 0; cfg_sel = 0; cfg_price = 0; cfg_stock = 0;
      repeat (2) @(negedge clk);
      compared++;
      if ({product_price, stock_count, price_valid, code_error, vend_ack, vend_fail} != 16'h0) begin
         mismatched++;
         $display("FAIL reset_outputs price=%0d stock=%0d pulses=%b%b%b%b need all 0",
                  product_price, stock_count, price_valid, code_error, vend_ack, vend_fail);
      end
      rst_n = 1'b1;
      // reset price map and stock
      look(4'b0001, 1, 5, 0);
      look(4'b0010, 2, 5, 0);
      look(4'b0100, 5, 5, 0);
      look(4'b1000, 10, 5, 0);
      // illegal codes
      look(4'b0000, 0, 0, 1);
      look(4'b0110, 0, 0, 1);
      vend(4'b0110, 0);
      look(4'b0010, 2, 5, 0);
      // price write with same-cycle lookup returns old price
      drive(1, 0, 4'b0100, 1, 0, 2'd2, 8'd37, 0, 5, 5, 0, 0);
      look(4'b0100, 37, 5, 0);
      // drain slot 3; first vend coincides with a lookup showing pre-decrement stock
      drive(1, 1, 4'b1000, 0, 0, 0, 0, 0, 10, 5, 0, 1);
      repeat (4) vend(4'b1000, 1);
      vend(4'b1000, 0);
      look(4'b1000, 10, 0, 0);
      // restock beats a same-cycle vend
      drive(0, 1, 4'b0001, 0, 1, 2'd0, 0, 4'd9, 0, 0, 0, 0);
      look(4'b0001, 1, 9, 0);
      // price-only write does not block a vend
      drive(0, 1, 4'b0001, 1, 0, 2'd0, 8'd3, 0, 0, 0, 0, 1);
      look(4'b0001, 3, 8, 0);
      // program slot 1, vend twice, then reset with a lookup in flight
      drive(0, 0, 4'b0, 1, 0, 2'd1, 8'd50, 0, 0, 0, 0, 0);
      vend(4'b0010, 1);
      vend(4'b0010, 1);
      rst_n = 1'b0;
      drive(1, 1, 4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      idle();
      look(4'b0010, 2, 5, 0);
      look(4'b0100, 5, 5, 0);
      look(4'b1000, 10, 5, 0);
      idle();
      compared++;
      if (product_price != 8'd10 || stock_count != 4'd5 || price_valid) begin
         mismatched++;
         $display("FAIL hold price=%0d stock=%0d valid=%0b need 10/5/0", product_price, stock_count, price_valid);
      end
      repeat (2) idle();
      compared++;
      if (lq.size() != 0 || vq.size() != 0) begin
         mismatched++;
         $display("FAIL missing_responses lookups=%0d vends=%0d need 0/0", lq.size(), vq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
